// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write-port arbiter for dual_clk_fifo (wclk domain).
// Shares the single FIFO write port between NREQ requesters, with a per-grant
// burst limit. Every write is gated by wfull. Grant, winc and wdata are
// combinational from the registered state so that wfull reaches winc in the
// same cycle.
module fifo_wr_arbiter #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned BURST = 4,
  localparam int unsigned OW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    wclk,
  input  logic                    wrst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DSIZE-1:0]   req_data,
  input  logic                    wfull,
  output logic [NREQ-1:0]         gnt,
  output logic                    winc,
  output logic [DSIZE-1:0]        wdata,
  output logic                    busy,
  output logic [OW-1:0]           owner,
  output logic [15:0]             wr_count
);

  localparam int unsigned   BW        = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [OW-1:0] LAST_IDX  = OW'(NREQ - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state, state_nxt;
  logic [OW-1:0]   owner_nxt;
  logic [OW-1:0]   ptr, ptr_nxt;
  logic [OW-1:0]   ptr_rel;
  logic [BW-1:0]   beat, beat_nxt;
  logic [15:0]     wr_count_nxt;
  logic [NREQ-1:0] own_onehot;
  logic            owner_req;
  logic            any_req;
  logic            xfer;
  logic            release_own;
  logic [OW-1:0]   pick_idle;
  logic [OW-1:0]   pick_rel;

  // First requesting index scanning start, start+1, ... modulo NREQ.
  function automatic logic [OW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [OW-1:0]   start);
    logic [OW-1:0] sel;
    logic          found;
    int unsigned   idx;
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(start) + i) % NREQ;
      if (!found && (((r >> idx) & NREQ'(1)) != '0)) begin
        sel   = OW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // Decode the owner index and derive the grant-side qualifiers.
  always_comb begin
    own_onehot = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      own_onehot[i] = (owner == OW'(i));
    end
    owner_req = |(req & own_onehot);
    any_req   = |req;
    ptr_rel   = (owner == LAST_IDX) ? '0 : owner + OW'(1);
    pick_idle = rr_pick(req, ptr);
    pick_rel  = rr_pick(req, ptr_rel);
  end

  // Write-port drive: only the owner may write, never while the FIFO is full.
  always_comb begin
    gnt   = '0;
    wdata = '0;
    if (state == OWN && !wfull) begin
      gnt = req & own_onehot;
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        wdata = wdata | req_data[i*DSIZE +: DSIZE];
      end
    end
    xfer = |gnt;
    winc = xfer;
    busy = (state == OWN);
  end

  // Ownership next-state: burst accounting, release and zero-bubble handoff.
  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    ptr_nxt      = ptr;
    beat_nxt     = beat;
    wr_count_nxt = wr_count;
    release_own  = 1'b0;

    if (xfer) begin
      wr_count_nxt = wr_count + 16'd1;
    end

    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = OWN;
          owner_nxt = pick_idle;
          beat_nxt  = '0;
        end
      end
      OWN: begin
        release_own = (xfer && (beat == LAST_BEAT)) || !owner_req;
        if (release_own) begin
          ptr_nxt  = ptr_rel;
          beat_nxt = '0;
          if (any_req) begin
            owner_nxt = pick_rel;
          end else begin
            state_nxt = IDLE;
          end
        end else if (xfer) begin
          beat_nxt = beat + BW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register; reset clears ownership so all write-port outputs drop at once.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state    <= IDLE;
      owner    <= '0;
      ptr      <= '0;
      beat     <= '0;
      wr_count <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      ptr      <= ptr_nxt;
      beat     <= beat_nxt;
      wr_count <= wr_count_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: randomized scoreboard bench for fifo_wr_arbiter.
// The reference model keeps an explicit priority list and a burst count;
// expected per-cycle outputs are queued by the driver and checked by a monitor.
module tb_fifo_wr_arbiter;

  localparam int unsigned DSIZE = 8;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned BURST = 4;
  localparam int unsigned OW    = 2;
  localparam int          NCYC  = 1600;

  logic                  wclk;
  logic                  wrst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*DSIZE-1:0] req_data;
  logic                  wfull;
  logic [NREQ-1:0]       gnt;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic                  busy;
  logic [OW-1:0]         owner;
  logic [15:0]           wr_count;

  fifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .BURST(BURST)) dut (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .req      (req),
    .req_data (req_data),
    .wfull    (wfull),
    .gnt      (gnt),
    .winc     (winc),
    .wdata    (wdata),
    .busy     (busy),
    .owner    (owner),
    .wr_count (wr_count)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct {
    logic [NREQ-1:0]  gnt;
    logic             winc;
    logic [DSIZE-1:0] wdata;
    logic             busy;
    logic [OW-1:0]    owner;
    logic [15:0]      wr_count;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: who owns the port, how many words it wrote in this grant,
  // and the priority order (index 0 = highest) used for the next pick.
  bit m_own;
  int m_owner;
  int m_beats;
  int m_order[NREQ];
  int m_count;

  function automatic logic bit_of(input logic [NREQ-1:0] v, input int k);
    logic [NREQ-1:0] s;
    s = v >> k;
    return s[0];
  endfunction

  task automatic m_set_order(input int start);
    for (int k = 0; k < NREQ; k++) m_order[k] = (start + k) % NREQ;
  endtask

  function automatic int m_first(input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++) begin
      if (bit_of(r, m_order[k])) return m_order[k];
    end
    return -1;
  endfunction

  task automatic model_step(input logic rst_ok, input logic [NREQ-1:0] r,
                            input logic [NREQ*DSIZE-1:0] d, input logic full,
                            output exp_t e);
    bit xfer;
    bit done;
    e.gnt = '0; e.winc = 1'b0; e.wdata = '0;
    e.busy = 1'b0; e.owner = '0; e.wr_count = '0;
    if (!rst_ok) begin
      m_own = 0; m_owner = 0; m_beats = 0; m_count = 0;
      m_set_order(0);
      return;
    end
    e.busy     = m_own;
    e.owner    = OW'(m_owner);
    e.wr_count = 16'(m_count);
    xfer = m_own && bit_of(r, m_owner) && !full;
    if (xfer) begin
      e.gnt   = NREQ'(1) << m_owner;
      e.winc  = 1'b1;
      e.wdata = DSIZE'(d >> (m_owner * DSIZE));
    end
    if (!m_own) begin
      if (r != '0) begin
        m_own   = 1;
        m_owner = m_first(r);
        m_beats = 0;
      end
    end else begin
      if (xfer) begin
        m_count = (m_count + 1) % 65536;
        m_beats++;
      end
      done = (xfer && m_beats == BURST) || !bit_of(r, m_owner);
      if (done) begin
        m_set_order((m_owner + 1) % NREQ);
        m_beats = 0;
        if (r != '0) m_owner = m_first(r);
        else         m_own = 0;
      end
    end
  endtask

  // Driver: protocol-respecting random requesters; data only changes once
  // the current word has been written or the request was idle.
  initial begin : driver
    exp_t            drv_e;
    logic [NREQ-1:0] prev_gnt;
    logic [3:0]      mask;
    int              p_raise, p_drop, p_full;
    int              wait_cnt;
    wrst_n   = 1'b1;
    req      = '0;
    req_data = '0;
    wfull    = 1'b0;
    prev_gnt = '0;
    #2 wrst_n = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge wclk);
      #1;
      mask = 4'b1111; p_raise = 100; p_drop = 0; p_full = 0;
      if (c >= 40 && c < 60)       mask = 4'b0001;
      else if (c >= 60 && c < 100) p_full = 50;
      else if (c >= 103) begin
        p_raise = 40; p_drop = 15; p_full = 25;
        if (c >= 1300 && c < 1360) mask = 4'b0100;
      end
      wrst_n = !(c < 4 || (c >= 100 && c < 103));
      for (int i = 0; i < NREQ; i++) begin
        if (!mask[i]) begin
          req[i] = 1'b0;
        end else if (prev_gnt[i]) begin
          req_data[i*DSIZE +: DSIZE] = 8'($urandom);
          req[i] = ($urandom_range(99) < 32'(p_raise));
        end else if (req[i]) begin
          if ($urandom_range(99) < 32'(p_drop)) req[i] = 1'b0;
        end else if ($urandom_range(99) < 32'(p_raise)) begin
          req[i] = 1'b1;
          req_data[i*DSIZE +: DSIZE] = 8'($urandom);
        end
      end
      wfull = ($urandom_range(99) < 32'(p_full));
      model_step(wrst_n, req, req_data, wfull, drv_e);
      sb_q.push_back(drv_e);
      prev_gnt = drv_e.gnt;
    end
    wait_cnt = 0;
    while (sb_q.size() != 0 && wait_cnt < 10) begin
      @(negedge wclk);
      #1;
      wait_cnt++;
    end
    if (sb_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Monitor: outputs are combinational, so every cycle presents a response.
  int   mon_cyc = 0;
  exp_t mon_e;
  always @(negedge wclk) begin
    mon_cyc++;
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      vectors++;
      if (gnt !== mon_e.gnt || winc !== mon_e.winc || wdata !== mon_e.wdata ||
          busy !== mon_e.busy || owner !== mon_e.owner || wr_count !== mon_e.wr_count) begin
        miscompares++;
        $display("FAIL cyc%0d outputs: got gnt=%b winc=%b wdata=%h busy=%b owner=%0d cnt=%0d, required gnt=%b winc=%b wdata=%h busy=%b owner=%0d cnt=%0d",
                 mon_cyc, gnt, winc, wdata, busy, owner, wr_count,
                 mon_e.gnt, mon_e.winc, mon_e.wdata, mon_e.busy, mon_e.owner, mon_e.wr_count);
      end
      vectors++;
      if (wfull && winc) begin
        miscompares++;
        $display("FAIL cyc%0d write_while_full: got winc=%b with wfull=1, required 0", mon_cyc, winc);
      end
    end
  end

endmodule
